// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported 8-byte-wide data memory.
// Each granted access runs a fixed IDLE->ACCESS->SETTLE->RESP sequence; accesses that would wrap are rejected.
module mem_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic              err,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] endereco,
   output logic [DATA_W-1:0] write_data,
   input  logic [DATA_W-1:0] read_data
);

   localparam int LP_BYTES = DATA_W / 8;
   // Highest start address whose last byte still fits below 2^ADDR_W.
   localparam logic [ADDR_W-1:0] LP_ADDR_MAX = {ADDR_W{1'b1}} - ADDR_W'(LP_BYTES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_SETTLE = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t             r_state;
   logic               r_last;
   logic               r_port;
   logic               r_we;
   logic               r_oob;
   logic               r_done0;
   logic               r_done1;
   logic               r_err;
   logic [DATA_W-1:0]  r_rdata;
   logic               r_mem_read;
   logic               r_mem_write;
   logic [ADDR_W-1:0]  r_endereco;
   logic [DATA_W-1:0]  r_write_data;

   logic               w_pick0;
   logic               w_pick1;
   logic               w_grant;
   logic               w_sel_we;
   logic [ADDR_W-1:0]  w_sel_addr;
   logic [DATA_W-1:0]  w_sel_wdata;
   logic               w_oob;

   // Round-robin pick and selection of the winning port's request fields.
   always_comb begin
      w_pick1     = req1 & (~req0 | ~r_last);
      w_pick0     = req0 & ~w_pick1;
      w_grant     = rst_n & (r_state == ST_IDLE) & (req0 | req1);
      w_sel_we    = 1'b0;
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      if (w_pick1) begin
         w_sel_we    = we1;
         w_sel_addr  = addr1;
         w_sel_wdata = wdata1;
      end else begin
         w_sel_we    = we0;
         w_sel_addr  = addr0;
         w_sel_wdata = wdata0;
      end
      w_oob = (w_sel_addr > LP_ADDR_MAX);
   end

   // Access sequencer: latches the granted request, drives the memory, returns the response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_last       <= 1'b1;
         r_port       <= 1'b0;
         r_we         <= 1'b0;
         r_oob        <= 1'b0;
         r_done0      <= 1'b0;
         r_done1      <= 1'b0;
         r_err        <= 1'b0;
         r_rdata      <= '0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_endereco   <= '0;
         r_write_data <= '0;
      end else begin
         r_done0 <= 1'b0;
         r_done1 <= 1'b0;
         r_err   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_grant) begin
                  r_state <= ST_ACCESS;
                  r_port  <= w_pick1;
                  r_last  <= w_pick1;
                  r_we    <= w_sel_we;
                  r_oob   <= w_oob;
                  // Rejected accesses never reach the memory pins.
                  if (!w_oob) begin
                     r_mem_read   <= ~w_sel_we;
                     r_mem_write  <= w_sel_we;
                     r_endereco   <= w_sel_addr;
                     r_write_data <= w_sel_wdata;
                  end
               end
            end
            ST_ACCESS: begin
               r_state <= ST_SETTLE;
            end
            ST_SETTLE: begin
               r_state     <= ST_RESP;
               r_mem_read  <= 1'b0;
               r_mem_write <= 1'b0;
               r_done0     <= ~r_port;
               r_done1     <= r_port;
               r_err       <= r_oob;
               if (r_oob) begin
                  r_rdata <= '0;
               end else if (!r_we) begin
                  r_rdata <= read_data;
               end
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state     <= ST_IDLE;
               r_mem_read  <= 1'b0;
               r_mem_write <= 1'b0;
            end
         endcase
      end
   end

   assign gnt0       = w_grant & w_pick0;
   assign gnt1       = w_grant & w_pick1;
   assign done0      = r_done0;
   assign done1      = r_done1;
   assign err        = r_err;
   assign rdata      = r_rdata;
   assign mem_read   = r_mem_read;
   assign mem_write  = r_mem_write;
   assign endereco   = r_endereco;
   assign write_data = r_write_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter with a byte-array memory and a transaction-level reference model.
module tb_mem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        req0, req1, we0, we1;
   logic [7:0]  addr0, addr1;
   logic [63:0] wdata0, wdata1;
   logic        gnt0, gnt1, done0, done1, err;
   logic [63:0] rdata;
   logic        mem_read, mem_write;
   logic [7:0]  endereco;
   logic [63:0] write_data;
   logic [63:0] read_data;

   logic [7:0]  tb_mem  [256];
   logic [7:0]  ref_mem [256];

   int          vectors     = 0;
   int          miscompares = 0;
   int          last_port   = 1;
   logic [63:0] exp_rdata   = 64'h0;

   mem_arbiter #(.ADDR_W(8), .DATA_W(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err),
      .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write),
      .endereco(endereco), .write_data(write_data), .read_data(read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Big-endian asynchronous-read memory.
   always_comb begin
      read_data = 64'h0;
      for (int i = 0; i < 8; i++) read_data[63-8*i -: 8] = tb_mem[endereco + 8'(i)];
   end

   always @(posedge clk) begin
      if (mem_write) begin
         for (int j = 0; j < 8; j++) tb_mem[endereco + 8'(j)] <= write_data[63-8*j -: 8];
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed still running, expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] ref_load(input logic [7:0] a);
      logic [63:0] v;
      v = 64'h0;
      for (int i = 0; i < 8; i++) v[63-8*i -: 8] = ref_mem[a + 8'(i)];
      return v;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_gnt"},   {62'h0, gnt0, gnt1}, 64'h0);
      check({tag, "_done"},  {62'h0, done0, done1}, 64'h0);
      check({tag, "_err"},   err, 64'h0);
      check({tag, "_mem"},   {62'h0, mem_read, mem_write}, 64'h0);
      check({tag, "_addr"},  endereco, 64'h0);
      check({tag, "_wdata"}, write_data, 64'h0);
      check({tag, "_rdata"}, rdata, 64'h0);
   endtask

   // One full transaction: call in an IDLE cycle; returns in the IDLE cycle after the response.
   task automatic txn(input logic r0, input logic r1,
                      input logic w0, input logic [7:0] a0, input logic [63:0] d0,
                      input logic w1, input logic [7:0] a1, input logic [63:0] d1);
      int          p;
      int          n;
      logic        w;
      logic [7:0]  a;
      logic [63:0] d;
      logic        oob;
      p   = (r0 && r1) ? (1 - last_port) : (r1 ? 1 : 0);
      w   = (p == 1) ? w1 : w0;
      a   = (p == 1) ? a1 : a0;
      d   = (p == 1) ? d1 : d0;
      oob = (a > 8'd248);
      req0 = r0; req1 = r1;
      we0 = w0; addr0 = a0; wdata0 = d0;
      we1 = w1; addr1 = a1; wdata1 = d1;
      #1;
      n = 0;
      while (!(gnt0 || gnt1) && n < 20) begin
         wait_clk();
         n++;
      end
      check("gnt_timeout", 64'(n < 20), 64'h1);
      check("gnt0", gnt0, 64'(p == 0));
      check("gnt1", gnt1, 64'(p == 1));
      wait_clk();
      req0 = 1'b0; req1 = 1'b0;
      for (int k = 0; k < 2; k++) begin
         check("mem_read",  mem_read,  64'(!oob && !w));
         check("mem_write", mem_write, 64'(!oob && w));
         if (!oob) begin
            check("endereco",   endereco,   64'(a));
            check("write_data", write_data, d);
         end
         check("done_early", {62'h0, done0, done1}, 64'h0);
         wait_clk();
      end
      if (oob) begin
         exp_rdata = 64'h0;
      end else if (w) begin
         for (int i = 0; i < 8; i++) ref_mem[a + 8'(i)] = d[63-8*i -: 8];
      end else begin
         exp_rdata = ref_load(a);
      end
      check("done0",     done0, 64'(p == 0));
      check("done1",     done1, 64'(p == 1));
      check("err",       err,   64'(oob));
      check("rdata",     rdata, exp_rdata);
      check("resp_mem",  {62'h0, mem_read, mem_write}, 64'h0);
      wait_clk();
      check("done_pulse", {62'h0, done0, done1}, 64'h0);
      last_port = p;
   endtask

   initial begin
      logic [7:0]  ra;
      logic [63:0] rd;
      int          mode;
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = 8'h0; addr1 = 8'h0; wdata0 = 64'h0; wdata1 = 64'h0;
      for (int i = 0; i < 256; i++) begin
         tb_mem[i]  = 8'($urandom);
         ref_mem[i] = tb_mem[i];
      end
      for (int i = 8; i < 15; i++) begin
         tb_mem[i]  = 8'h00;
         ref_mem[i] = 8'h00;
      end
      tb_mem[15]  = 8'h06;
      ref_mem[15] = 8'h06;

      #1;
      check_all_zero("reset");

      // Contention from reset: both held, grants alternate every 4 cycles starting with port 0.
      wait_clk();
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
      addr0 = 8'd0; addr1 = 8'd8;
      #1;
      check("reset_gnt", {62'h0, gnt0, gnt1}, 64'h0);
      rst_n = 1'b1;
      #1;
      for (int c = 0; c < 16; c++) begin
         check("cont_gnt0",  gnt0,  64'(c % 8 == 0));
         check("cont_gnt1",  gnt1,  64'(c % 8 == 4));
         check("cont_done0", done0, 64'(c % 8 == 3));
         check("cont_done1", done1, 64'(c % 8 == 7));
         wait_clk();
      end
      req0 = 1'b0; req1 = 1'b0;
      last_port = 1;
      exp_rdata = ref_load(8'd8);
      check("cont_rdata", rdata, exp_rdata);
      wait_clk();

      // Basic load and store/load round trip.
      txn(1'b1, 1'b0, 1'b0, 8'd8, 64'h0, 1'b0, 8'd0, 64'h0);
      check("load8_rdata", rdata, 64'h0000000000000006);
      txn(1'b0, 1'b1, 1'b0, 8'd0, 64'h0, 1'b1, 8'd16, 64'h0102030405060708);
      txn(1'b1, 1'b0, 1'b0, 8'd16, 64'h0, 1'b0, 8'd0, 64'h0);
      check("st_ld_rdata", rdata, 64'h0102030405060708);
      check("byte16", 64'(tb_mem[16]), 64'h01);

      // Address bounds.
      txn(1'b1, 1'b0, 1'b0, 8'd249, 64'h0, 1'b0, 8'd0, 64'h0);
      txn(1'b1, 1'b0, 1'b0, 8'd248, 64'h0, 1'b0, 8'd0, 64'h0);
      txn(1'b0, 1'b1, 1'b1, 8'd0, 64'h0, 1'b1, 8'd255, 64'hDEADBEEFCAFEF00D);

      // Reset in the middle of a load.
      req0 = 1'b1; we0 = 1'b0; addr0 = 8'd8;
      #1;
      check("mid_gnt0", gnt0, 64'h1);
      wait_clk();
      req0 = 1'b0;
      wait_clk();
      check("mid_settle_rd", mem_read, 64'h1);
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      wait_clk();
      check("midrst_done0", done0, 64'h0);
      wait_clk();
      check("midrst_done0b", done0, 64'h0);
      rst_n = 1'b1;
      last_port = 1;
      exp_rdata = 64'h0;
      wait_clk();
      txn(1'b1, 1'b0, 1'b0, 8'd8, 64'h0, 1'b0, 8'd0, 64'h0);

      // Randomized traffic with single and contending requests.
      for (int i = 0; i < 30; i++) begin
         mode = int'($urandom_range(0, 2));
         ra = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 248));
         rd = {$urandom, $urandom};
         txn(1'(mode != 1), 1'(mode != 0),
             1'($urandom_range(0, 1)), ra, rd,
             1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), {$urandom, $urandom});
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, byte-address width of the data memory.
REQ-002 Parameter DATA_W, default 64, access width; fixed at 8 bytes, big-endian (byte at addr holds bits 63:56).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req0 / req1  input  1  access request from requester 0 (load/store unit) / requester 1 (debug/loader).
REQ-006 we0 / we1  input  1  1 = store, 0 = load; sampled with req.
REQ-007 addr0 / addr1  input  ADDR_W  byte address of first byte.
REQ-008 wdata0 / wdata1  input  DATA_W  store data.
REQ-009 gnt0 / gnt1  output  1  one-cycle grant pulse; request latched this cycle.
REQ-010 done0 / done1  output  1  one-cycle completion pulse.
REQ-011 err  output  1  valid with done; 1 = access rejected.
REQ-012 rdata  output  DATA_W  load result; valid with done, held until next done.
REQ-013 mem_read / mem_write  output  1  memory read/write enables.
REQ-014 endereco  output  ADDR_W  memory address.
REQ-015 write_data  output  DATA_W  memory write data.
REQ-016 read_data  input  DATA_W  memory read data.

Function
REQ-017 FSM states IDLE, ACCESS, SETTLE, RESP; IDLE->ACCESS on grant; ACCESS->SETTLE->RESP->IDLE unconditionally.
REQ-018 In IDLE with any req high: grant exactly one port, latch its we/addr/wdata, pulse its gnt, enter ACCESS next cycle.
REQ-019 Arbitration round-robin: only one requesting -> that one; both -> port not granted last; after reset port 0 has priority.
REQ-020 Requests are sampled only in IDLE; req high in ACCESS/SETTLE/RESP is ignored (no queueing, no gnt).
REQ-021 Requester holds req until gnt; dropping req before gnt withdraws it with no side effect.
REQ-022 ACCESS and SETTLE: endereco = latched addr, write_data = latched wdata, mem_read = !we, mem_write = we, held stable both cycles.
REQ-023 End of SETTLE: rdata registered from read_data for loads; rdata unchanged for stores.
REQ-024 RESP: all memory enables 0; done of the granted port pulses for one cycle with err.
REQ-025 Latency fixed: done 3 cycles after gnt; next gnt no earlier than the cycle after done (peak 1 access / 4 cycles).
REQ-026 Bounds: addr > 2^ADDR_W - 8 (default > 248) would wrap; such access SHALL NOT assert mem_read/mem_write, SHALL give err=1, rdata=0, same latency.
REQ-027 Outside ACCESS/SETTLE, mem_read=mem_write=0, endereco and write_data hold last values.
REQ-028 gnt0/gnt1 and done0/done1 never both high in one cycle.
REQ-029 Arithmetic on addresses is unsigned ADDR_W; no wrap-around access is ever issued.

Reset
REQ-030 rst_n low: state IDLE, round-robin pointer favours port 0, gnt*/done*/err/mem_read/mem_write = 0, endereco = 0, write_data = 0, rdata = 0, immediately and asynchronously.
REQ-031 Reset mid-access aborts it: no done issued; a store already in ACCESS may have written memory, all else discarded.
REQ-032 First grant possible on first rising edge after rst_n deasserts.

Verification
REQ-033 Load: req0, we0=0, addr0=8, memory bytes 8..15 = 00..06 -> gnt0 at T, mem_read T+1..T+2, done0 T+3, err=0, rdata=64'h6.
REQ-034 Store then load: req1, we1=1, addr1=16, wdata1=64'h0102030405060708 -> done1; load addr 16 -> rdata=64'h0102030405060708; byte 16 = 8'h01.
REQ-035 Contention: req0 and req1 held continuously after reset -> grants alternate 0,1,0,1, spaced 4 cycles apart.
REQ-036 Bounds: load addr0=249 -> mem_read never asserted, done0 with err=1, rdata=0; addr0=248 -> err=0.
REQ-037 Reset mid-op: rst_n low during SETTLE of a load -> all outputs 0 at once, no done0; after release fresh req0 granted normally.
